// File: rtl/note_sequencer_if.sv
// Bus bundle between the front-end, song ROM, buzzer and the note sequencer.
interface note_sequencer_if #(
    parameter int unsigned ADDR_W = 6
) ();
    logic [6:0]        key_low;
    logic [2:0]        key_pitch;
    logic              play_start;
    logic              play_stop;
    logic [ADDR_W-1:0] rom_addr;
    logic [17:0]       rom_data;
    logic [6:0]        low;
    logic [2:0]        pitch;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] note_idx;

    // Front-end / ROM / buzzer side
    modport master (
        output key_low, key_pitch, play_start, play_stop, rom_data,
        input  rom_addr, low, pitch, busy, done, note_idx
    );

    // Sequencer side
    modport slave (
        input  key_low, key_pitch, play_start, play_stop, rom_data,
        output rom_addr, low, pitch, busy, done, note_idx
    );
endinterface

// File: rtl/note_sequencer.sv
// Note sequencer: forwards live keys to the buzzer in manual mode, or walks
// a synchronous song ROM (note, octave, duration) with a silent gap per note.
module note_sequencer #(
    parameter int unsigned TICK_DIV  = 1000000,
    parameter int unsigned GAP_TICKS = 2,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned SONG_LEN  = 64
) (
    input  logic           clk,
    input  logic           rst,
    note_sequencer_if.slave bus
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W   = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]   GAP_INIT  = GAP_W'(GAP_TICKS);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        low_q, low_d;
    logic [2:0]        pitch_q, pitch_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]        dur_q, dur_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              wrap;
    logic              advance;
    logic [6:0]        rom_note;
    logic [2:0]        rom_pitch;
    logic [7:0]        rom_dur;

    assign rom_note  = bus.rom_data[17:11];
    assign rom_pitch = bus.rom_data[10:8];
    assign rom_dur   = bus.rom_data[7:0];
    assign wrap      = (presc_q == PRESC_MAX);

    // Only one-hot octave codes reach the buzzer; anything else maps to mid.
    function automatic logic [2:0] norm_pitch(input logic [2:0] p);
        case (p)
            3'b001, 3'b010, 3'b100: return p;
            default:                return 3'b010;
        endcase
    endfunction

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            low_q   <= '0;
            pitch_q <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            presc_q <= '0;
            dur_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            pitch_q <= pitch_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            dur_q   <= dur_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic: sequencing, tick counting and buzzer output control.
    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        pitch_d = pitch_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        presc_d = presc_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        advance = 1'b0;

        case (state_q)
            S_IDLE: begin
                low_d   = bus.key_low;
                pitch_d = norm_pitch(bus.key_pitch);
                if (bus.play_start && !bus.play_stop) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                if (rom_dur == 8'd0) begin
                    low_d   = '0;
                    state_d = S_DONE;
                end else begin
                    low_d   = rom_note;
                    pitch_d = norm_pitch(rom_pitch);
                    idx_d   = addr_q;
                    presc_d = '0;
                    dur_d   = rom_dur;
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                if (wrap) begin
                    dur_d = dur_q - 8'd1;
                    if (dur_q == 8'd1) begin
                        low_d = '0;
                        if (GAP_TICKS > 0) begin
                            gap_d   = GAP_INIT;
                            state_d = S_GAP;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                presc_d = wrap ? '0 : presc_q + 1'b1;
                if (wrap) begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == GAP_W'(1)) advance = 1'b1;
                end
            end
            S_DONE: begin
                low_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (advance) begin
            if (addr_q == LAST_ADDR) begin
                state_d = S_DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
            end
        end

        // Abort overrides whatever the sequencing above decided.
        if (bus.play_stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            low_d   = '0;
            pitch_d = '0;
            addr_d  = '0;
        end
    end

    assign bus.rom_addr = addr_q;
    assign bus.low      = low_q;
    assign bus.pitch    = pitch_q;
    assign bus.note_idx = idx_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = (state_q == S_DONE);

endmodule
